btn_conditioner: RTL and testbench

- Conditions the five raw push-buttons (U, L, R, D, C) before the game/colour stage.
- Per button: 2-flop synchroniser, counter-based debounce, single-cycle press/release pulses, and auto-repeat of the press pulse while the button is held.
- Replaces the free-running shared-count sampler, so the game logic consumes clean one-cycle move events instead of doing its own edge detection.

---
 rtl/btn_pkg.sv | 27 ++
 rtl/btn_channel.sv | 119 +++++++++++
 rtl/btn_conditioner.sv | 36 +++
 tb/tb_btn_conditioner.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared constants for the push-button conditioner: button bit positions,
// repeat-FSM state encoding and default 25 MHz timing.
package btn_pkg;

  localparam int BTN_U = 4;
  localparam int BTN_L = 3;
  localparam int BTN_R = 2;
  localparam int BTN_D = 1;
  localparam int BTN_C = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rep_state_e;

  // 10 ms debounce, 300 ms first repeat, 50 ms repeat period at 25 MHz
  localparam int DEF_DEBOUNCE_CYCLES = 250000;
  localparam int DEF_REPEAT_DELAY    = 7500000;
  localparam int DEF_REPEAT_PERIOD   = 1250000;
  localparam logic [4:0] DEF_REPEAT_MASK = 5'b01110;

  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button: 2-flop synchroniser, counter debounce, registered press/release
// pulses and an optional auto-repeat of the press pulse while held.
module btn_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter bit REPEAT_EN       = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int RW = $clog2(maxInt(REPEAT_DELAY, REPEAT_PERIOD)) + 1;
  localparam logic [DW-1:0] DEB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  logic          sync1_q, sync2_q;
  logic          level_q;
  logic [DW-1:0] debCnt_q;
  rep_state_e    state_q, state_d;
  logic [RW-1:0] repCnt_q, repCnt_d;
  logic          press_q, press_d;
  logic          release_q, release_d;

  logic debDone, rise, fall;

  assign debDone = (sync2_q != level_q) && (debCnt_q == DEB_LAST);
  assign rise    = debDone && sync2_q;
  assign fall    = debDone && !sync2_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      level_q   <= 1'b0;
      debCnt_q  <= '0;
      state_q   <= IDLE;
      repCnt_q  <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      // Any agreeing cycle restarts the debounce window
      if (sync2_q == level_q) begin
        debCnt_q <= '0;
      end else if (debDone) begin
        level_q  <= sync2_q;
        debCnt_q <= '0;
      end else begin
        debCnt_q <= debCnt_q + DW'(1);
      end
      state_q   <= state_d;
      repCnt_q  <= repCnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // Fall wins over a repeat due in the same cycle; non-repeating channels park
  // in DELAY with the counter frozen.
  always_comb begin
    state_d   = state_q;
    repCnt_d  = repCnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (fall) begin
      state_d   = IDLE;
      repCnt_d  = '0;
      release_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise) begin
            press_d  = 1'b1;
            state_d  = DELAY;
            repCnt_d = '0;
          end
        end
        DELAY: begin
          if (REPEAT_EN) begin
            if (repCnt_q == DELAY_LAST) begin
              press_d  = 1'b1;
              repCnt_d = '0;
              state_d  = REPEAT;
            end else begin
              repCnt_d = repCnt_q + RW'(1);
            end
          end
        end
        REPEAT: begin
          if (repCnt_q == PERIOD_LAST) begin
            press_d  = 1'b1;
            repCnt_d = '0;
          end else begin
            repCnt_d = repCnt_q + RW'(1);
          end
        end
        default: begin
          state_d  = IDLE;
          repCnt_d = '0;
        end
      endcase
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/btn_conditioner.sv
// Conditions the five raw push-buttons into debounced levels and one-cycle
// press/release events; each bit is an independent btn_channel.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int N               = 5,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter logic [N-1:0] REPEAT_MASK = N'(DEF_REPEAT_MASK)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] btn_in,
  output logic [N-1:0] btn_level,
  output logic [N-1:0] btn_press,
  output logic [N-1:0] btn_release
);

  for (genvar i = 0; i < N; i++) begin : gChannel
    btn_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD),
      .REPEAT_EN      (REPEAT_MASK[i])
    ) uChannel (
      .clk      (clk),
      .reset    (reset),
      .btn_i    (btn_in[i]),
      .level_o  (btn_level[i]),
      .press_o  (btn_press[i]),
      .release_o(btn_release[i])
    );
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner with short timing (debounce 4,
// repeat delay 10, repeat period 3); expected events are queued at stimulus time.
module tb_btn_conditioner;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] btnIn;
  logic [4:0] btnLevel, btnPress, btnRelease;

  typedef struct {
    int         cycle;
    logic [4:0] press;
    logic [4:0] rel;
    logic [4:0] level;
  } event_t;

  event_t expQ[$];
  int cycleCount = 0;
  int errors = 0;
  int checks = 0;

  btn_conditioner #(
    .N              (5),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3),
    .REPEAT_MASK    (5'b01110)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_in     (btnIn),
    .btn_level  (btnLevel),
    .btn_press  (btnPress),
    .btn_release(btnRelease)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic pushExp(input int cyc, input logic [4:0] p, input logic [4:0] r,
                         input logic [4:0] l);
    event_t e;
    e.cycle = cyc;
    e.press = p;
    e.rel   = r;
    e.level = l;
    expQ.push_back(e);
  endtask

  task automatic waitUntil(input int c);
    while (cycleCount < c) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [4:0] value, input int atCycle);
    waitUntil(atCycle);
    btnIn = value;
  endtask

  // Monitor: every cycle with a press or release pulse consumes one expectation
  always @(negedge clk) begin
    event_t e;
    if (reset === 1'b1 && (btnPress !== 5'd0 || btnRelease !== 5'd0)) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedEvent@%0d: got press=%b release=%b expected none",
                 cycleCount, btnPress, btnRelease);
      end else begin
        e = expQ.pop_front();
        checkOutput($sformatf("event@%0d cycle", e.cycle), cycleCount, e.cycle);
        checkOutput($sformatf("event@%0d press", e.cycle), {27'd0, btnPress}, {27'd0, e.press});
        checkOutput($sformatf("event@%0d release", e.cycle), {27'd0, btnRelease}, {27'd0, e.rel});
        checkOutput($sformatf("event@%0d level", e.cycle), {27'd0, btnLevel}, {27'd0, e.level});
      end
    end
  end

  initial begin
    repeat (3000) @(posedge clk);
    $display("[TB] FAIL watchdog: got no end of stimulus expected finish by 3000 cycles");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int a, b, g, h, u, s, m, r;
    reset = 1'b0;
    btnIn = 5'd0;

    waitUntil(2);
    checkOutput("resetLevel", {27'd0, btnLevel}, 32'd0);
    checkOutput("resetPress", {27'd0, btnPress}, 32'd0);
    checkOutput("resetRelease", {27'd0, btnRelease}, 32'd0);
    waitUntil(3);
    reset = 1'b1;

    // L held: press at +6, repeats 10 then every 3; release lands on a due repeat
    a = 6;
    applyStimulus(5'b01000, a);
    pushExp(a + 6, 5'b01000, 5'b00000, 5'b01000);
    for (int k = 0; k < 7; k++) pushExp(a + 16 + 3 * k, 5'b01000, 5'b00000, 5'b01000);
    waitUntil(a + 8);
    checkOutput("holdLevelL", {27'd0, btnLevel}, 32'h08);
    applyStimulus(5'b00000, a + 31);
    pushExp(a + 37, 5'b00000, 5'b01000, 5'b00000);

    // R bounces 1,0,1,0 then holds; only the final stable 1 counts
    b = a + 45;
    applyStimulus(5'b00100, b);
    applyStimulus(5'b00000, b + 1);
    applyStimulus(5'b00100, b + 2);
    applyStimulus(5'b00000, b + 3);
    applyStimulus(5'b00100, b + 4);
    pushExp(b + 10, 5'b00100, 5'b00000, 5'b00100);
    waitUntil(b + 9);
    checkOutput("bounceLevelR", {27'd0, btnLevel}, 32'h00);
    applyStimulus(5'b00000, b + 11);
    pushExp(b + 17, 5'b00000, 5'b00100, 5'b00000);

    // C glitch of DEBOUNCE_CYCLES-1 is ignored; a DEBOUNCE_CYCLES pulse registers
    g = b + 25;
    applyStimulus(5'b00001, g);
    applyStimulus(5'b00000, g + 3);
    waitUntil(g + 10);
    checkOutput("glitchLevelC", {27'd0, btnLevel}, 32'h00);
    h = g + 15;
    applyStimulus(5'b00001, h);
    pushExp(h + 6, 5'b00001, 5'b00000, 5'b00001);
    applyStimulus(5'b00000, h + 4);
    pushExp(h + 10, 5'b00000, 5'b00001, 5'b00000);

    // U never repeats
    u = h + 20;
    applyStimulus(5'b10000, u);
    pushExp(u + 6, 5'b10000, 5'b00000, 5'b10000);
    applyStimulus(5'b00000, u + 46);
    pushExp(u + 52, 5'b00000, 5'b10000, 5'b00000);

    // L and D together
    s = u + 60;
    applyStimulus(5'b01010, s);
    pushExp(s + 6, 5'b01010, 5'b00000, 5'b01010);
    for (int k = 0; k < 3; k++) pushExp(s + 16 + 3 * k, 5'b01010, 5'b00000, 5'b01010);
    applyStimulus(5'b00000, s + 17);
    pushExp(s + 23, 5'b00000, 5'b01010, 5'b00000);

    // Reset while R is repeating, then release reset with R still held
    m = s + 30;
    applyStimulus(5'b00100, m);
    pushExp(m + 6, 5'b00100, 5'b00000, 5'b00100);
    pushExp(m + 16, 5'b00100, 5'b00000, 5'b00100);
    waitUntil(m + 16);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("midResetLevel", {27'd0, btnLevel}, 32'd0);
    checkOutput("midResetPress", {27'd0, btnPress}, 32'd0);
    checkOutput("midResetRelease", {27'd0, btnRelease}, 32'd0);
    r = m + 19;
    waitUntil(r);
    reset = 1'b1;
    pushExp(r + 6, 5'b00100, 5'b00000, 5'b00100);
    for (int k = 0; k < 3; k++) pushExp(r + 16 + 3 * k, 5'b00100, 5'b00000, 5'b00100);
    applyStimulus(5'b00000, r + 17);
    pushExp(r + 23, 5'b00000, 5'b00100, 5'b00000);

    waitUntil(r + 35);
    checkOutput("leftoverExpected", expQ.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
